dac_update_sequencer: RTL and testbench
=======================================

# dac_update_sequencer

Sequencer that sits on the OPB master side of the DACx0504 serial interface and shares it between four channel requesters (one per DAC channel). After reset it runs a fixed init sequence: SYNC register write, then GAIN register write. It then serves channel update requests in batches, writing each requested DAC data register and closing every batch with a TRIGGER (LDAC) write so that all channels in the batch update together. Writes are paced by a fixed gap counter because the downstream interface queues commands in a 16-deep FIFO with no back-pressure.

## Interface
- WR_GAP, 256: minimum OPB_CLK cycles between consecutive M_WE pulses; ≥ 2. Covers 27 serial clocks × 8 OPB clocks plus margin.
- INIT_GAIN, 16'h0000: data written to the GAIN register (addr 4'h4) during init.
- SYNC_MASK, 16'h000F: data written to the SYNC register (addr 4'h2); all channels update on LDAC.
- TRIG_DATA, 16'h0010: data written to the TRIGGER register (addr 4'h5); LDAC bit.
- AUTO_TRIG, 1: 1 = close each batch with a TRIGGER write; 0 = never issue TRIGGER.
- OPB_CLK  in  1  system clock, 100 MHz; all logic on the rising edge.
- OPB_RST  in  1  reset, synchronous, active-high.
- REQ  in  4  per-channel update request, level; held high until the matching ACK.
- REQ_DATA  in  64  channel n code in bits [16n+15:16n].
- ACK  out  4  one-cycle pulse; asserts in the same cycle as that channel's M_WE.
- BUSY  out  1  high in every state except IDLE.
- INIT_DONE  out  1  high once init completes; stays high until reset.
- M_ADDR  out  32  {28'h0, register addr}.
- M_DI  out  32  {16'h0, data}.
- M_WE  out  1  one-cycle write strobe to the DAC interface.
- M_RE  out  1  tied 0; this block never reads.

## Operation
States: INIT_SYNC, INIT_GAIN, IDLE, WRITE, TRIG, GAP.

Init sequence:
- INIT_SYNC: issue SYNC write (addr 4'h2, SYNC_MASK), then wait for the gap counter.
- INIT_GAIN: issue GAIN write (addr 4'h4, INIT_GAIN), then wait for the gap counter.
- Then move to IDLE and set INIT_DONE.

IDLE:
- When REQ != 0 and the gap counter is 0, register snapshot ← REQ and go to WRITE.
- REQ is ignored before INIT_DONE.

WRITE:
- Select the lowest-index bit set in snapshot.
- If REQ[n] is still high: pulse M_WE with addr 4'h8+n and data REQ_DATA[n]; pulse ACK[n] in the same cycle; clear snapshot[n]; load the gap counter.
- If REQ[n] has dropped: clear snapshot[n] silently (no write, no gap, evaluate the next bit in the following cycle).
- After each issued write, wait for the gap counter before the next write.
- When snapshot = 0:
  - at least one write issued and AUTO_TRIG = 1 → go to TRIG;
  - otherwise → go to GAP if a gap is pending, else IDLE.

TRIG:
- Issue TRIGGER write (addr 4'h5, TRIG_DATA), load the gap counter, go to GAP.

GAP:
- Wait for the gap counter to reach 0, then go to IDLE.

Fairness and arbitration rules:
- Requests that rise mid-batch wait for the next batch.
- A channel is served at most once per batch.
- Order within a batch is fixed: ch0 → ch3.

Gap counter:
- Width $clog2(WR_GAP).
- Loads WR_GAP-1 on every M_WE and decrements to 0.
- Next M_WE is allowed only when the counter = 0, so writes are ≥ WR_GAP cycles apart, including across state changes.

Reset (any cycle, including mid-batch):
- Next edge: state INIT_SYNC, snapshot 0, counter 0.
- All outputs reset to 0: ACK, BUSY, INIT_DONE, M_ADDR, M_DI, M_WE, M_RE. BUSY goes high one cycle later.
- Serial transactions already queued downstream are not cancelled by this block.

## Timing
- Cycle 0 = first edge with OPB_RST low:
  - SYNC M_WE at cycle 1;
  - GAIN M_WE at cycle 1+WR_GAP;
  - INIT_DONE high and BUSY low from cycle 1+2·WR_GAP.
- Request latency from IDLE: REQ sampled high at edge t → snapshot at t; first M_WE/ACK in cycle t+1.
- Batch of k served channels with AUTO_TRIG = 1:
  - M_WE at t+1, t+1+WR_GAP, …, t+1+(k-1)·WR_GAP;
  - TRIGGER at t+1+k·WR_GAP;
  - IDLE (BUSY low) at t+1+(k+1)·WR_GAP.
- M_ADDR and M_DI hold their value after the pulse until the next write; they are only valid while M_WE = 1.
- REQ_DATA is sampled only in the ACK cycle.

## Test plan
- Reset release with WR_GAP=8 → SYNC write {0x2, 0x000F} at cycle 1, GAIN write {0x4, 0x0000} at cycle 9, INIT_DONE at cycle 17, exactly 2 M_WE pulses.
- REQ=4'b1010 with data ch1=0x1234, ch3=0xABCD after init → writes to addr 0x9 then 0xB, 8 cycles apart; ACK[1] then ACK[3] coincident with each write; TRIGGER {0x5, 0x0010} 8 cycles after the last write.
- REQ[0] rises during a batch serving ch2 → ch0 is not written in that batch; next batch writes addr 0x8 ≥ 8 cycles after the previous TRIGGER.
- Snapshot 4'b0011, REQ[0] dropped before its turn → only addr 0x9 written plus TRIGGER; no ACK[0]. Snapshot 4'b0001 with REQ[0] dropped → no writes and no TRIGGER.
- AUTO_TRIG=0 with REQ=4'hF → 4 writes (0x8..0xB) spaced WR_GAP apart, no addr 0x5 write.
- OPB_RST asserted one cycle after the ch1 write of a batch → all outputs 0 next edge; after release the init sequence repeats and no stale ACK occurs.

Source files
------------

// File: rtl/dac_update_sequencer.sv
// Shares the DACx0504 OPB write port among four channel requesters: SYNC/GAIN init, batched data writes, LDAC trigger.
// First write one cycle after REQ capture, then one write per WR_GAP cycles; no back-pressure, the gap counter paces the downstream FIFO.
module dac_update_sequencer #(
  parameter int          WR_GAP    = 256,
  parameter logic [15:0] INIT_GAIN = 16'h0000,
  parameter logic [15:0] SYNC_MASK = 16'h000F,
  parameter logic [15:0] TRIG_DATA = 16'h0010,
  parameter bit          AUTO_TRIG = 1'b1
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [3:0]  REQ,
  input  logic [63:0] REQ_DATA,
  output logic [3:0]  ACK,
  output logic        BUSY,
  output logic        INIT_DONE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_DI,
  output logic        M_WE,
  output logic        M_RE
);

  localparam int GW = $clog2(WR_GAP);

  typedef enum logic [2:0] {
    S_INIT_SYNC,
    S_INIT_GAIN,
    S_IDLE,
    S_WRITE,
    S_TRIG,
    S_GAP
  } state_t;

  state_t        state, state_n;
  logic [3:0]    snap, snap_n;
  logic [GW-1:0] gap_cnt;
  logic          gap_zero;
  logic          issued, issued_n;
  logic          run_q;
  logic          done_n;
  logic          we_n;
  logic [3:0]    ack_n;
  logic [3:0]    addr_q, addr_n;
  logic [15:0]   data_q, data_n;
  logic [1:0]    sel;

  assign gap_zero = (gap_cnt == '0);
  assign M_ADDR   = {28'h0, addr_q};
  assign M_DI     = {16'h0, data_q};
  assign M_RE     = 1'b0;

  always_comb begin
    state_n  = state;
    snap_n   = snap;
    issued_n = issued;
    done_n   = INIT_DONE;
    we_n     = 1'b0;
    ack_n    = 4'b0000;
    addr_n   = addr_q;
    data_n   = data_q;
    sel      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (snap[i]) sel = 2'(i);
    end

    case (state)
      // run_q delays the first write by one cycle after reset release
      S_INIT_SYNC: if (run_q) begin
        we_n    = 1'b1;
        addr_n  = 4'h2;
        data_n  = SYNC_MASK;
        state_n = S_INIT_GAIN;
      end
      S_INIT_GAIN: if (gap_zero) begin
        we_n    = 1'b1;
        addr_n  = 4'h4;
        data_n  = INIT_GAIN;
        state_n = S_GAP;
      end
      S_IDLE: if (INIT_DONE && (REQ != 4'b0000) && gap_zero) begin
        snap_n   = REQ;
        issued_n = 1'b0;
        state_n  = S_WRITE;
      end
      S_WRITE: begin
        if (snap == 4'b0000) begin
          if (issued && AUTO_TRIG) state_n = S_TRIG;
          else if (!gap_zero)      state_n = S_GAP;
          else                     state_n = S_IDLE;
        end else if (!REQ[sel]) begin
          snap_n[sel] = 1'b0;
        end else if (gap_zero) begin
          we_n        = 1'b1;
          ack_n[sel]  = 1'b1;
          addr_n      = {2'b10, sel};
          data_n      = REQ_DATA[{sel, 4'b0000} +: 16];
          snap_n[sel] = 1'b0;
          issued_n    = 1'b1;
        end
      end
      S_TRIG: if (gap_zero) begin
        we_n    = 1'b1;
        addr_n  = 4'h5;
        data_n  = TRIG_DATA;
        state_n = S_GAP;
      end
      S_GAP: if (gap_zero) begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      default: state_n = S_INIT_SYNC;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state     <= S_INIT_SYNC;
      snap      <= 4'b0000;
      gap_cnt   <= '0;
      issued    <= 1'b0;
      run_q     <= 1'b0;
      INIT_DONE <= 1'b0;
      BUSY      <= 1'b0;
      M_WE      <= 1'b0;
      ACK       <= 4'b0000;
      addr_q    <= 4'h0;
      data_q    <= 16'h0000;
    end else begin
      state     <= state_n;
      snap      <= snap_n;
      issued    <= issued_n;
      run_q     <= 1'b1;
      INIT_DONE <= done_n;
      BUSY      <= (state_n != S_IDLE);
      M_WE      <= we_n;
      ACK       <= ack_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      if (we_n)           gap_cnt <= GW'(WR_GAP - 1);
      else if (!gap_zero) gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: tb/tb_dac_update_sequencer.sv
// Randomized bench for dac_update_sequencer: write events are logged and compared with expectations derived from batch timing rules.
module tb_dac_update_sequencer;

  localparam int          G    = 8;
  localparam logic [15:0] TRIG = 16'h0010;

  typedef struct packed {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ack;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000, req2 = 4'b0000;
  logic [63:0] rdat = '0, rdat2 = '0;
  logic [3:0]  ack, ack2;
  logic        busy, busy2, init_done, init_done2, we, we2, re, re2;
  logic [31:0] addr, addr2, di, di2;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  wr_t log_q[$];
  wr_t log2_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_update_sequencer #(.WR_GAP(G)) dut (
    .OPB_CLK(clk), .OPB_RST(rst), .REQ(req), .REQ_DATA(rdat),
    .ACK(ack), .BUSY(busy), .INIT_DONE(init_done),
    .M_ADDR(addr), .M_DI(di), .M_WE(we), .M_RE(re)
  );

  dac_update_sequencer #(.WR_GAP(G), .AUTO_TRIG(1'b0)) dut_nt (
    .OPB_CLK(clk), .OPB_RST(rst), .REQ(req2), .REQ_DATA(rdat2),
    .ACK(ack2), .BUSY(busy2), .INIT_DONE(init_done2),
    .M_ADDR(addr2), .M_DI(di2), .M_WE(we2), .M_RE(re2)
  );

  function automatic wr_t mk(input int c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] k);
    wr_t r;
    r.cyc = c; r.addr = a; r.data = d; r.ack = k;
    return r;
  endfunction

  function automatic wr_t at1(input int i);
    if (i < log_q.size()) return log_q[i];
    return mk(-1, '0, '0, '0);
  endfunction

  function automatic wr_t at2(input int i);
    if (i < log2_q.size()) return log2_q[i];
    return mk(-1, '0, '0, '0);
  endfunction

  function automatic string fmt(input wr_t r);
    return $sformatf("cyc=%0d addr=%h data=%h ack=%b", r.cyc, r.addr, r.data, r.ack);
  endfunction

  // One cycle: sample at the falling edge, log write/ack activity, requesters drop REQ on ACK.
  task automatic step();
    @(negedge clk);
    if (we || ack != 4'b0000)   log_q.push_back(mk(cyc, addr, di, ack));
    if (we2 || ack2 != 4'b0000) log2_q.push_back(mk(cyc, addr2, di2, ack2));
    req  = req & ~ack;
    req2 = req2 & ~ack2;
  endtask

  task automatic test_reset();
    int  t0, done_c, idle_c;
    wr_t e;
    rst = 1'b1; req = 4'b0000; req2 = 4'b0000;
    step(); step(); step();
    checks++;
    if ({we, ack, busy, init_done, re, addr, di} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b ack=%b busy=%b done=%b re=%b addr=%h di=%h, want all zero",
               we, ack, busy, init_done, re, addr, di);
    end
    log_q.delete(); log2_q.delete();
    rst = 1'b0; t0 = cyc + 1; done_c = -1; idle_c = -1;
    step();
    checks++;
    if (busy !== 1'b1 || we !== 1'b0) begin
      errors++; $display("FAIL busy_after_release: got busy=%b we=%b, want busy=1 we=0", busy, we);
    end
    for (int i = 0; i < 2*G + 6; i++) begin
      step();
      if (done_c < 0 && init_done === 1'b1) done_c = cyc;
      if (idle_c < 0 && busy === 1'b0)      idle_c = cyc;
    end
    checks++;
    if (log_q.size() != 2) begin errors++; $display("FAIL init_write_count: got %0d, want 2", log_q.size()); end
    e = mk(t0 + 1, 32'h2, 32'h000F, 4'b0000);
    checks++;
    if (at1(0) !== e) begin errors++; $display("FAIL init_sync: got %s, want %s", fmt(at1(0)), fmt(e)); end
    e = mk(t0 + 1 + G, 32'h4, 32'h0000, 4'b0000);
    checks++;
    if (at1(1) !== e) begin errors++; $display("FAIL init_gain: got %s, want %s", fmt(at1(1)), fmt(e)); end
    checks++;
    if (done_c != t0 + 1 + 2*G) begin errors++; $display("FAIL init_done_cycle: got %0d, want %0d", done_c, t0 + 1 + 2*G); end
    checks++;
    if (idle_c != t0 + 1 + 2*G) begin errors++; $display("FAIL init_idle_cycle: got %0d, want %0d", idle_c, t0 + 1 + 2*G); end
    checks++;
    if (log2_q.size() != 2 || init_done2 !== 1'b1) begin
      errors++; $display("FAIL init_no_trig_inst: got writes=%0d done=%b, want 2 and 1", log2_q.size(), init_done2);
    end
  endtask

  task automatic test_pair();
    int  t, idle_c;
    wr_t e[3];
    rdat = {16'hABCD, 16'($urandom), 16'h1234, 16'($urandom)};
    log_q.delete();
    req = 4'b1010; t = cyc + 1; idle_c = -1;
    step();
    for (int i = 0; i < 3*G + 6; i++) begin
      step();
      if (idle_c < 0 && busy === 1'b0) idle_c = cyc;
    end
    e[0] = mk(t + 1,       32'h9, 32'h1234, 4'b0010);
    e[1] = mk(t + 1 + G,   32'hB, 32'hABCD, 4'b1000);
    e[2] = mk(t + 1 + 2*G, 32'h5, 32'(TRIG), 4'b0000);
    checks++;
    if (log_q.size() != 3) begin errors++; $display("FAIL pair_count: got %0d, want 3", log_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (at1(i) !== e[i]) begin errors++; $display("FAIL pair_write%0d: got %s, want %s", i, fmt(at1(i)), fmt(e[i])); end
    end
    checks++;
    if (idle_c != t + 1 + 3*G) begin errors++; $display("FAIL pair_idle: got %0d, want %0d", idle_c, t + 1 + 3*G); end
    checks++;
    if (req !== 4'b0000) begin errors++; $display("FAIL pair_req_left: got %b, want 0000", req); end
  endtask

  task automatic test_midbatch();
    int  t;
    wr_t e[4];
    rdat = {$urandom, $urandom};
    log_q.delete();
    req = 4'b0100; t = cyc + 1;
    step(); step(); step();
    req[0] = 1'b1;
    for (int i = 0; i < 4*G + 6; i++) step();
    e[0] = mk(t + 1,       32'hA, {16'h0, rdat[47:32]}, 4'b0100);
    e[1] = mk(t + 1 + G,   32'h5, 32'(TRIG), 4'b0000);
    e[2] = mk(t + 3 + 2*G, 32'h8, {16'h0, rdat[15:0]}, 4'b0001);
    e[3] = mk(t + 3 + 3*G, 32'h5, 32'(TRIG), 4'b0000);
    checks++;
    if (log_q.size() != 4) begin errors++; $display("FAIL mid_count: got %0d, want 4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (at1(i) !== e[i]) begin errors++; $display("FAIL mid_write%0d: got %s, want %s", i, fmt(at1(i)), fmt(e[i])); end
    end
    checks++;
    if (at1(2).cyc - at1(1).cyc < G) begin
      errors++; $display("FAIL mid_gap_after_trig: got %0d, want >= %0d", at1(2).cyc - at1(1).cyc, G);
    end
  endtask

  task automatic test_drop();
    int  t;
    wr_t e0, e1;
    rdat = {$urandom, $urandom};
    log_q.delete();
    req = 4'b0011; t = cyc + 1;
    step();
    req[0] = 1'b0;
    for (int i = 0; i < 3*G + 6; i++) step();
    e0 = mk(t + 2,     32'h9, {16'h0, rdat[31:16]}, 4'b0010);
    e1 = mk(t + 2 + G, 32'h5, 32'(TRIG), 4'b0000);
    checks++;
    if (log_q.size() != 2) begin errors++; $display("FAIL drop_count: got %0d, want 2", log_q.size()); end
    checks++;
    if (at1(0) !== e0) begin errors++; $display("FAIL drop_write: got %s, want %s", fmt(at1(0)), fmt(e0)); end
    checks++;
    if (at1(1) !== e1) begin errors++; $display("FAIL drop_trig: got %s, want %s", fmt(at1(1)), fmt(e1)); end
    log_q.delete();
    req = 4'b0001;
    step();
    req = 4'b0000;
    for (int i = 0; i < 2*G; i++) step();
    checks++;
    if (log_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_all: got writes=%0d busy=%b, want 0 and 0", log_q.size(), busy);
    end
  endtask

  task automatic test_random();
    int         t, k, idle_c, exp_idle;
    logic [3:0] mask;
    wr_t        exp_q[$];
    for (int it = 0; it < 8; it++) begin
      mask = 4'($urandom_range(1, 15));
      rdat = {$urandom, $urandom};
      t = cyc + 1; k = 0; exp_q.delete();
      for (int ch = 0; ch < 4; ch++) begin
        if (mask[ch]) begin
          exp_q.push_back(mk(t + 1 + k*G, 32'(8 + ch), {16'h0, rdat[16*ch +: 16]}, 4'(1 << ch)));
          k++;
        end
      end
      exp_q.push_back(mk(t + 1 + k*G, 32'h5, 32'(TRIG), 4'b0000));
      exp_idle = t + 1 + (k + 1)*G;
      log_q.delete(); idle_c = -1;
      req = mask;
      step();
      for (int i = 0; i < 5*G + 4; i++) begin
        step();
        if (idle_c < 0 && busy === 1'b0) idle_c = cyc;
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count mask=%b: got %0d, want %0d", it, mask, log_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (at1(i) !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_write%0d mask=%b: got %s, want %s", it, i, mask, fmt(at1(i)), fmt(exp_q[i]));
        end
      end
      checks++;
      if (idle_c != exp_idle) begin errors++; $display("FAIL rand%0d_idle: got %0d, want %0d", it, idle_c, exp_idle); end
    end
  endtask

  task automatic test_no_trig();
    int  t;
    wr_t e;
    rdat2 = {$urandom, $urandom};
    log2_q.delete();
    req2 = 4'hF; t = cyc + 1;
    step();
    for (int i = 0; i < 5*G + 6; i++) step();
    checks++;
    if (log2_q.size() != 4) begin errors++; $display("FAIL notrig_count: got %0d, want 4", log2_q.size()); end
    for (int i = 0; i < 4; i++) begin
      e = mk(t + 1 + i*G, 32'(8 + i), {16'h0, rdat2[16*i +: 16]}, 4'(1 << i));
      checks++;
      if (at2(i) !== e) begin errors++; $display("FAIL notrig_write%0d: got %s, want %s", i, fmt(at2(i)), fmt(e)); end
    end
    checks++;
    if (busy2 !== 1'b0 || req2 !== 4'b0000) begin
      errors++; $display("FAIL notrig_end: got busy=%b req=%b, want 0 and 0000", busy2, req2);
    end
  endtask

  task automatic test_reset_mid();
    int  t, t0, done_c;
    wr_t e;
    rdat = {$urandom, $urandom};
    log_q.delete();
    req = 4'b1110; t = cyc + 1;
    step(); step();
    e = mk(t + 1, 32'h9, {16'h0, rdat[31:16]}, 4'b0010);
    checks++;
    if (at1(0) !== e) begin errors++; $display("FAIL rstmid_ch1: got %s, want %s", fmt(at1(0)), fmt(e)); end
    rst = 1'b1;
    step();
    checks++;
    if ({we, ack, busy, init_done, re, addr, di} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got we=%b ack=%b busy=%b done=%b re=%b addr=%h di=%h, want all zero",
               we, ack, busy, init_done, re, addr, di);
    end
    req = 4'b0000; log_q.delete();
    rst = 1'b0; t0 = cyc + 1; done_c = -1;
    step();
    for (int i = 0; i < 2*G + 6; i++) begin
      step();
      if (done_c < 0 && init_done === 1'b1) done_c = cyc;
    end
    checks++;
    if (log_q.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d, want 2", log_q.size()); end
    e = mk(t0 + 1, 32'h2, 32'h000F, 4'b0000);
    checks++;
    if (at1(0) !== e) begin errors++; $display("FAIL rstmid_sync: got %s, want %s", fmt(at1(0)), fmt(e)); end
    e = mk(t0 + 1 + G, 32'h4, 32'h0000, 4'b0000);
    checks++;
    if (at1(1) !== e) begin errors++; $display("FAIL rstmid_gain: got %s, want %s", fmt(at1(1)), fmt(e)); end
    checks++;
    if (done_c != t0 + 1 + 2*G) begin errors++; $display("FAIL rstmid_done: got %0d, want %0d", done_c, t0 + 1 + 2*G); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_midbatch();
    test_drop();
    test_random();
    test_no_trig();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
